// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor now,
// adder/comparator later): FSM state encoding, default width, bit-cell helpers.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SERIAL_N = 16;

  // One-bit difference of x - y - bin.
  function automatic logic sub_diff(input logic x, input logic y, input logic bin);
    return x ^ y ^ bin;
  endfunction

  // Borrow out of x - y - bin: a borrow occurs when y beats x outright, or on a tie with a pending borrow.
  function automatic logic sub_borrow(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// Combinational one-bit full subtractor; the single arithmetic cell that the
// serial subtractor reuses on every clock.
module full_sub_cell
  import serial_arith_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = sub_diff(x, y, bin);
  assign bout = sub_borrow(x, y, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, one bit per clock, LSB first,
// valid/ready on both sides. Optional signed overflow output under SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int N = SERIAL_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t        state_r;
  logic [N-1:0]  a_sr_r;
  logic [N-1:0]  b_sr_r;
  logic [N-2:0]  diff_sr_r;
  logic          br_r;
  logic [CW-1:0] cnt_r;
  logic          d_s;
  logic          br_next_s;
  logic [N-1:0]  diff_next_s;

`ifdef SERIAL_SUB_OVF_EN
  logic          a_msb_r;
  logic          b_msb_r;
`endif

  full_sub_cell u_cell (
    .x    (a_sr_r[0]),
    .y    (b_sr_r[0]),
    .bin  (br_r),
    .d    (d_s),
    .bout (br_next_s)
  );

  // Only N-1 bits are kept between edges; the final bit goes straight into diff.
  assign diff_next_s = {d_s, diff_sr_r};

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      a_sr_r    <= {N{1'b0}};
      b_sr_r    <= {N{1'b0}};
      diff_sr_r <= {(N-1){1'b0}};
      br_r      <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= {N{1'b0}};
      bout      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_r   <= 1'b0;
      b_msb_r   <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sr_r    <= a;
            b_sr_r    <= b;
            br_r      <= bin;
            cnt_r     <= {CW{1'b0}};
            in_ready  <= 1'b0;
            state_r   <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_r   <= a[N-1];
            b_msb_r   <= b[N-1];
`endif
          end else begin
            in_ready  <= 1'b1;
          end
        end
        SHIFT: begin
          a_sr_r    <= {1'b0, a_sr_r[N-1:1]};
          b_sr_r    <= {1'b0, b_sr_r[N-1:1]};
          diff_sr_r <= diff_next_s[N-1:1];
          br_r      <= br_next_s;
          if (cnt_r == CNT_LAST) begin
            diff      <= diff_next_s;
            bout      <= br_next_s;
            out_valid <= 1'b1;
            state_r   <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf       <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
`endif
          end else begin
            cnt_r     <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (N=16); ovf checks are
// compiled in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int N = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_tests;
  int n_fail;

  serial_subtractor #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Waits (bounded) for in_ready, presents operands, returns just after the accept edge.
  task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    a = av;
    b = bv;
    bin = bi;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 200);
  endtask

  task automatic release_result(input string tag, input logic [N-1:0] held);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_ir_back"}, {31'd0, in_ready}, 32'd1);
    check_eq({tag, "_diff_held"}, {16'd0, diff}, {16'd0, held});
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic bi, input logic [N-1:0] ed, input logic eb, input logic eo);
    int lat;
    send(av, bv, bi);
    wait_result(lat);
    check_eq({tag, "_latency"}, lat, N);
    check_eq({tag, "_diff"}, {16'd0, diff}, {16'd0, ed});
    check_eq({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
`ifdef SERIAL_SUB_OVF_EN
    check_eq({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
    if (eo !== 1'b0 && eo !== 1'b1) check_eq({tag, "_ovf_arg"}, {31'd0, eo}, 32'd0);
`endif
    release_result(tag, ed);
  endtask

  initial begin
    int lat;
    int c1;
    int c2;
    logic pv;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0000;
    b         = 16'h0000;
    bin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_diff", {16'd0, diff}, 32'd0);
    check_eq("rst_bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_op("zero_minus_one", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_op("ffff_minus_one", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    run_op("equal_bin",      16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_op("neg_ovf",        16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_op("pos_ovf",        16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

    // Backpressure with stray in_valid pulses during SHIFT and DONE.
    send(16'hFF2A, 16'hD4AA, 1'b0);
    a = 16'h1234;
    b = 16'h0001;
    in_valid = 1'b1;
    wait_result(lat);
    check_eq("bp_latency", lat, N);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_diff", {16'd0, diff}, 32'h2A80);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    check_eq("bp_bout", {31'd0, bout}, 32'd0);
    in_valid = 1'b0;
    release_result("bp", 16'h2A80);

    // Back-to-back: second result follows the first by N+2 cycles.
    @(negedge clk);
    out_ready = 1'b1;
    a = 16'h1000;
    b = 16'h0001;
    bin = 1'b0;
    in_valid = 1'b1;
    c1 = -1;
    c2 = -1;
    pv = 1'b0;
    for (int cyc = 1; cyc <= 100 && c2 < 0; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) begin
        a = 16'h0003;
        b = 16'h0007;
        bin = 1'b1;
      end
      if (out_valid && !pv) begin
        if (c1 < 0) begin
          c1 = cyc;
          check_eq("b2b_diff1", {16'd0, diff}, 32'h0FFF);
          check_eq("b2b_bout1", {31'd0, bout}, 32'd0);
        end else begin
          c2 = cyc;
          in_valid = 1'b0;
          check_eq("b2b_diff2", {16'd0, diff}, 32'hFFFB);
          check_eq("b2b_bout2", {31'd0, bout}, 32'd1);
        end
      end
      pv = out_valid;
    end
    in_valid = 1'b0;
    check_eq("b2b_gap", c2 - c1, N + 2);
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset 5 cycles into SHIFT aborts immediately.
    send(16'h1234, 16'h0034, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("abort_diff", {16'd0, diff}, 32'd0);
    check_eq("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("abort_bout", {31'd0, bout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_abort", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor. It computes diff = a - b - bin at one bit per clock, LSB first, using a single registered borrow.
- It is the inverse-operation companion to the team's N-bit ripple adder. It trades area for latency: one full-subtractor cell and shift registers instead of N cells.
- Operands arrive and results leave on valid/ready handshakes, so the block drops into the team's streaming arithmetic paths.

Parameters:
- N, 16: operand/result width in bits; legal range N >= 2.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: operands a, b, bin are valid.
- in_ready, output, 1: block can accept operands; high only in IDLE.
- a, input, N: minuend (unsigned).
- b, input, N: subtrahend (unsigned).
- bin, input, 1: borrow-in.
- out_valid, output, 1: diff/bout (and ovf) are valid.
- out_ready, input, 1: consumer accepts the result.
- diff, output, N: (a - b - bin) mod 2^N.
- bout, output, 1: borrow-out; 1 iff a < b + bin (unsigned).
- ovf, output, 1: signed overflow; exists only when the macro below is defined.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, diff=0, bout=0, ovf=0.
  - Shift registers, borrow register and bit counter are cleared.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture a and b into shift registers, load borrow register with bin, clear counter, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each edge takes bit x=a_sr[0] and y=b_sr[0] and the borrow register br.
  - d = x^y^br; br_next = (~x&y) | (~(x^y)&br).
  - d is shifted into diff_sr at the MSB; a_sr and b_sr shift right; counter increments.
  - On the edge where counter==N-1: go to DONE.
- DONE:
  - out_valid=1; diff = diff_sr; bout = br.
  - diff and bout are held stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE, out_valid drops to 0.
  - diff and bout keep their last value until the next result.
- Latency: operands accepted at edge k, out_valid high after edge k+N. Throughput is one result per N+2 cycles when out_ready is held high.
- in_valid asserted while not in IDLE is ignored; no capture, no error.
- out_ready asserted while out_valid=0 has no effect.
- The accept handshake in IDLE is not combinationally dependent on out_ready.
- Counter width is $clog2(N). No wrap beyond N-1 is reachable.
- Reset asserted mid-SHIFT or in DONE aborts the operation immediately. No partial result is presented.
- Arithmetic is purely modulo 2^N. bout is the only unsigned out-of-range indicator.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Port ovf exists.
  - The block keeps a copy of a[N-1] and b[N-1] at load.
  - In DONE, ovf = (a_msb != b_msb) && (diff[N-1] != a_msb). This is the signed two's-complement overflow of a - b - bin.
  - ovf is reset to 0 and held with diff.
- Not defined: no ovf port, no MSB copy registers. All other behaviour is identical.

Decomposition:
- Shared package serial_arith_pkg:
  - State enum {IDLE, SHIFT, DONE}.
  - Default width constant SERIAL_N = 16.
  - Reused by future bit-serial adder/comparator blocks.
- One natural sub-module: full_sub_cell. It is combinational, with inputs x, y, bin and outputs d, bout (equations above), and is instantiated once inside serial_subtractor.

Test Plan:
- N=16, a=0x0000, b=0x0001, bin=0 -> after 16 cycles out_valid=1, diff=0xFFFF, bout=1; with macro, ovf=0.
- a=0xFFFF, b=0x0001, bin=0 -> diff=0xFFFE, bout=0. a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1.
- Macro on: a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1. a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
- Backpressure: result 0x2A80 (a=0xFF2A, b=0xD4AA), out_ready low for 3 cycles -> out_valid stays 1 and diff stays 0x2A80. in_valid pulses during SHIFT/DONE are ignored, and in_ready stays 0 until the cycle after out_ready=1.
- Back-to-back: in_valid and out_ready held high, two operand pairs -> second result's out_valid follows the first by exactly N+2 cycles.
- Drop rst_n low 5 cycles into SHIFT -> same cycle: out_valid=0, diff=0, in_ready=1. A new operand pair after release yields a correct result.
